adder_seq_32x8: RTL and testbench

Multi-cycle 32-bit add/subtract sequencer that shares a single 8-bit carry-lookahead adder (`x_adder_cl_8x1`) across four byte slices, least significant byte first, with a registered inter-byte carry. Sits in the processor ALU as the area-reduced adder path. Operands and a result register are owned by this block. The requester sees a start/busy/done handshake.

---
 rtl/adder_seq_32x8.sv | 165 ++++++++++++++++
 tb/tb_adder_seq_32x8.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/adder_seq_32x8.sv
// 32-bit add/subtract sequencer: one shared 8-bit carry-lookahead adder walks
// four byte slices LSB first, carrying between slices through a register.

module x_adder_cl_8x1 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [4:0] lo;
  logic [4:0] hi;

  // Flattened 4-bit lookahead: carry i+1 as a sum of generate terms gated by
  // the propagate products above them, plus the carry-in term.
  function automatic logic [4:0] cla4(input logic [3:0] gg, input logic [3:0] pp,
                                      input logic ci);
    logic [4:0] c;
    logic       term;
    logic       prod;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      term = gg[i];
      prod = pp[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & gg[j]);
        prod = prod & pp[j];
      end
      c[i+1] = term | (prod & ci);
    end
    return c;
  endfunction

  always_comb begin
    g   = a_i & b_i;
    p   = a_i ^ b_i;
    lo  = cla4(g[3:0], p[3:0], c_i);
    hi  = cla4(g[7:4], p[7:4], lo[4]);
    s_o = p ^ {hi[3:0], lo[3:0]};
    c_o = hi[4];
  end

endmodule

module adder_seq_32x8 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        c_out,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        c_out_q, c_out_d;
  logic        ovf_q, ovf_d;

  logic [4:0]  sl_idx;
  logic [7:0]  sl_a;
  logic [7:0]  sl_b;
  logic [7:0]  sl_sum;
  logic        sl_co;
  logic        accept;

  assign sl_idx = {cnt_q, 3'b000};
  assign sl_a   = opa_q[sl_idx +: 8];
  assign sl_b   = opb_q[sl_idx +: 8];
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  x_adder_cl_8x1 u_cla (
    .a_i (sl_a),
    .b_i (sl_b),
    .c_i (carry_q),
    .s_o (sl_sum),
    .c_o (sl_co)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = start ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the slice carry.
  always_comb begin
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    if (accept) begin
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = 2'd0;
      acc_d   = '0;
    end else if (state_q == S_BUSY) begin
      acc_d[sl_idx +: 8] = sl_sum;
      carry_d            = sl_co;
      if (cnt_q == 2'd3) begin
        result_d = {sl_sum, acc_q[23:0]};
        c_out_d  = sl_co;
        ovf_d    = (opa_q[31] == opb_q[31]) && (sl_sum[7] != opa_q[31]);
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    busy     = (state_q == S_BUSY);
    done     = (state_q == S_DONE);
    result   = result_q;
    c_out    = c_out_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_adder_seq_32x8.sv
// Directed and random bench for adder_seq_32x8 against an arithmetic reference.

module tb_adder_seq_32x8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        c_out;
  logic        overflow;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] prev_res = 32'h0;

  adder_seq_32x8 dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then derive the 32-bit view and flags.
  task automatic ref_op(input logic [31:0] ra, input logic [31:0] rb, input logic rsub,
                        output logic [31:0] r, output logic c, output logic v);
    longint sa;
    longint sb;
    longint exact;
    longint unsigned us;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    exact = rsub ? (sa - sb) : (sa + sb);
    v = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    if (rsub) begin
      r = ra - rb;
      c = (ra >= rb);
    end else begin
      us = longint'(ra) + longint'(rb);
      r = ra + rb;
      c = (us > 64'hFFFF_FFFF);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tsub);
    logic [31:0] er;
    logic        ec;
    logic        ev;
    ref_op(ta, tb, tsub, er, ec, ev);
    start = 1'b1; a = ta; b = tb; sub = tsub;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " busy"}, {31'b0, busy}, 32'd1);
      chk({tag, " nodone"}, {31'b0, done}, 32'd0);
      chk({tag, " hold"}, result, prev_res);
      @(posedge clock); #1;
    end
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " idle"}, {31'b0, busy}, 32'd0);
    chk({tag, " result"}, result, er);
    chk({tag, " c_out"}, {31'b0, c_out}, {31'b0, ec});
    chk({tag, " ovf"}, {31'b0, overflow}, {31'b0, ev});
    prev_res = er;
    @(posedge clock); #1;
    chk({tag, " pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst c_out", {31'b0, c_out}, 32'd0);
    chk("rst ovf", {31'b0, overflow}, 32'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    run_op("basic add", 32'h0000_00FF, 32'h0000_0001, 1'b0);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst c_out", {31'b0, c_out}, 32'd0);
    chk("midrst ovf", {31'b0, overflow}, 32'd0);
    @(negedge clock); reset = 1'b0;
    prev_res = 32'h0;
    @(posedge clock); #1;
    for (int k = 0; k < 6; k++) begin
      chk("midrst nodone", {31'b0, done}, 32'd0);
      chk("midrst nobusy", {31'b0, busy}, 32'd0);
      @(posedge clock); #1;
    end

    run_op("carry chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("ovf add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("ovf sub", 32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op("borrow sub", 32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op("sub equal", 32'h1234_5678, 32'h1234_5678, 1'b1);

    // Handshake: start in BUSY ignored; start held through DONE accepted.
    start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_0001; sub = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    chk("hs first done", {31'b0, done}, 32'd1);
    chk("hs first result", result, 32'h2345_6789);
    start = 1'b1; a = 32'd3; b = 32'd4; sub = 1'b0;
    @(posedge clock); #1;
    start = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 4; k++) begin
      chk("hs b2b busy", {31'b0, busy}, 32'd1);
      chk("hs b2b nodone", {31'b0, done}, 32'd0);
      chk("hs b2b hold", result, 32'h2345_6789);
      @(posedge clock); #1;
    end
    chk("hs second done", {31'b0, done}, 32'd1);
    chk("hs second result", result, 32'h0000_0007);
    prev_res = 32'h0000_0007;
    @(posedge clock); #1;

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 1) ra = 32'h8000_0000 ^ {31'b0, ra[0]};
      if (n % 7 == 3) rb = ra;
      run_op("random", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
